// File: rtl/m5_kbd_pkg.sv
// Shared types and the PS/2 set-2 to Sord M5 matrix map for the keyboard bridge.
// Define M5_KBD_CURSOR_EN to map the extended arrow keys onto the M5 cursor keys.
package m5_kbd_pkg;

  localparam int NUM_ROWS = 7;
  localparam int NUM_COLS = 8;

  localparam logic [2:0] ROW_MOD  = 3'd0;
  localparam logic [2:0] ROW_NUM  = 3'd1;
  localparam logic [2:0] ROW_QWE  = 3'd2;
  localparam logic [2:0] ROW_ASD  = 3'd3;
  localparam logic [2:0] ROW_ZXC  = 3'd4;
  localparam logic [2:0] ROW_PUNC = 3'd5;
  localparam logic [2:0] ROW_MISC = 3'd6;

  typedef struct packed {
    logic       pressed;
    logic [2:0] row;
    logic [2:0] col;
  } key_evt_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_map_t;

  function automatic key_map_t km(input logic [2:0] r, input logic [2:0] c);
    km = '{valid: 1'b1, row: r, col: c};
  endfunction

  // Key is {ext, code}; anything not listed is unmapped.
  function automatic key_map_t lookup_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    case ({ext, code})
      9'h014: m = km(ROW_MOD, 3'd0);   9'h011: m = km(ROW_MOD, 3'd1);
      9'h012: m = km(ROW_MOD, 3'd2);   9'h059: m = km(ROW_MOD, 3'd3);
      9'h029: m = km(ROW_MOD, 3'd6);   9'h05A: m = km(ROW_MOD, 3'd7);
      9'h016: m = km(ROW_NUM, 3'd0);   9'h01E: m = km(ROW_NUM, 3'd1);
      9'h026: m = km(ROW_NUM, 3'd2);   9'h025: m = km(ROW_NUM, 3'd3);
      9'h02E: m = km(ROW_NUM, 3'd4);   9'h036: m = km(ROW_NUM, 3'd5);
      9'h03D: m = km(ROW_NUM, 3'd6);   9'h03E: m = km(ROW_NUM, 3'd7);
      9'h015: m = km(ROW_QWE, 3'd0);   9'h01D: m = km(ROW_QWE, 3'd1);
      9'h024: m = km(ROW_QWE, 3'd2);   9'h02D: m = km(ROW_QWE, 3'd3);
      9'h02C: m = km(ROW_QWE, 3'd4);   9'h035: m = km(ROW_QWE, 3'd5);
      9'h03C: m = km(ROW_QWE, 3'd6);   9'h043: m = km(ROW_QWE, 3'd7);
      9'h01C: m = km(ROW_ASD, 3'd0);   9'h01B: m = km(ROW_ASD, 3'd1);
      9'h023: m = km(ROW_ASD, 3'd2);   9'h02B: m = km(ROW_ASD, 3'd3);
      9'h034: m = km(ROW_ASD, 3'd4);   9'h033: m = km(ROW_ASD, 3'd5);
      9'h03B: m = km(ROW_ASD, 3'd6);   9'h042: m = km(ROW_ASD, 3'd7);
      9'h01A: m = km(ROW_ZXC, 3'd0);   9'h022: m = km(ROW_ZXC, 3'd1);
      9'h021: m = km(ROW_ZXC, 3'd2);   9'h02A: m = km(ROW_ZXC, 3'd3);
      9'h032: m = km(ROW_ZXC, 3'd4);   9'h031: m = km(ROW_ZXC, 3'd5);
      9'h03A: m = km(ROW_ZXC, 3'd6);   9'h041: m = km(ROW_ZXC, 3'd7);
      9'h046: m = km(ROW_PUNC, 3'd0);  9'h045: m = km(ROW_PUNC, 3'd1);
      9'h04E: m = km(ROW_PUNC, 3'd2);  9'h055: m = km(ROW_PUNC, 3'd3);
      9'h049: m = km(ROW_PUNC, 3'd4);  9'h04A: m = km(ROW_PUNC, 3'd5);
      9'h04C: m = km(ROW_PUNC, 3'd6);  9'h05D: m = km(ROW_PUNC, 3'd7);
      9'h044: m = km(ROW_MISC, 3'd0);  9'h04D: m = km(ROW_MISC, 3'd1);
      9'h054: m = km(ROW_MISC, 3'd2);  9'h05B: m = km(ROW_MISC, 3'd3);
`ifdef M5_KBD_CURSOR_EN
      9'h175: m = km(ROW_MISC, 3'd4);  9'h172: m = km(ROW_MISC, 3'd5);
      9'h16B: m = km(ROW_MISC, 3'd6);  9'h174: m = km(ROW_MISC, 3'd7);
`else
`endif
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/m5_kbd_evt_fifo.sv
// Small key-event FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module m5_kbd_evt_fifo
  import m5_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          push_i,
  input  key_evt_t      evt_i,
  input  logic          pop_i,
  output key_evt_t      evt_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  key_evt_t      mem_q [FIFO_DEPTH];
  key_evt_t      mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = evt_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign evt_o   = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;

endmodule

// File: rtl/m5_ps2_keymatrix.sv
// hps_io ps2_key events -> Sord M5 keyboard matrix, applied through a FIFO at HOLD_CYCLES spacing.
// M5_KBD_CURSOR_EN (see m5_kbd_pkg) enables the cursor-key mapping.
module m5_ps2_keymatrix
  import m5_kbd_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key_i,
  input  logic [2:0]  row_sel_i,
  output logic [7:0]  row_data_o,
  output logic        any_key_o,
  output logic        overflow_o
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  logic            primed_q, primed_d, tog_ref_q, tog_ref_d;
  logic [1:0]      vld_pipe_q, vld_pipe_d;  // [0] detect stage, [1] mapped event ready to push
  logic            s1_ext_q, s1_ext_d, s1_pressed_q, s1_pressed_d;
  logic [7:0]      s1_code_q, s1_code_d;
  key_evt_t        s2_evt_q, s2_evt_d, pop_evt;
  key_map_t        map;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0][7:0] matrix_q, matrix_d;
  logic [7:0]      row_data_q, row_data_d;
  logic            overflow_q, overflow_d;
  logic            fifo_full, pop;
  logic [CW-1:0]   fifo_cnt;

  always_comb begin
    primed_d     = 1'b1;
    tog_ref_d    = ps2_key_i[10];
    s1_ext_d     = s1_ext_q;
    s1_code_d    = s1_code_q;
    s1_pressed_d = s1_pressed_q;
    vld_pipe_d[0] = primed_q && (ps2_key_i[10] != tog_ref_q);
    if (vld_pipe_d[0]) begin
      s1_pressed_d = ps2_key_i[9];
      s1_ext_d     = ps2_key_i[8];
      s1_code_d    = ps2_key_i[7:0];
    end
    map           = lookup_key(s1_ext_q, s1_code_q);
    vld_pipe_d[1] = vld_pipe_q[0] && map.valid;
    s2_evt_d      = '{pressed: s1_pressed_q, row: map.row, col: map.col};

    pop        = (fifo_cnt != '0) && (hold_cnt_q == '0);
    overflow_d = vld_pipe_q[1] && fifo_full && !pop;
    hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - 1'b1 : hold_cnt_q;
    matrix_d   = matrix_q;
    if (pop) begin
      matrix_d[pop_evt.row][pop_evt.col] = pop_evt.pressed;
      hold_cnt_d = HOLD_LOAD;
    end
    matrix_d[7] = '0;
    // Registering from the next-state matrix keeps the toggle-to-output latency at four cycles.
    row_data_d  = matrix_d[row_sel_i];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      primed_q     <= 1'b0;
      tog_ref_q    <= 1'b0;
      vld_pipe_q   <= '0;
      s1_ext_q     <= 1'b0;
      s1_code_q    <= '0;
      s1_pressed_q <= 1'b0;
      s2_evt_q     <= '0;
      hold_cnt_q   <= '0;
      matrix_q     <= '0;
      row_data_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      primed_q     <= primed_d;
      tog_ref_q    <= tog_ref_d;
      vld_pipe_q   <= vld_pipe_d;
      s1_ext_q     <= s1_ext_d;
      s1_code_q    <= s1_code_d;
      s1_pressed_q <= s1_pressed_d;
      s2_evt_q     <= s2_evt_d;
      hold_cnt_q   <= hold_cnt_d;
      matrix_q     <= matrix_d;
      row_data_q   <= row_data_d;
      overflow_q   <= overflow_d;
    end
  end

  m5_kbd_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (vld_pipe_q[1]),
    .evt_i   (s2_evt_q),
    .pop_i   (pop),
    .evt_o   (pop_evt),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign row_data_o = row_data_q;
  assign any_key_o  = |matrix_q;
  assign overflow_o = overflow_q;

endmodule
